// File: rtl/dac_sample_sequencer_if.sv
// Control/FIFO/DAC signal bundle for dac_sample_sequencer.
// The master side is the bus wrapper plus FIFO; the slave side is the sequencer.
interface dac_sample_sequencer_if #(
  parameter int DW     = 10,
  parameter int PRE_W  = 8,
  parameter int DIV_W  = 20,
  parameter int UCNT_W = 8
);
  logic              en;
  logic [PRE_W-1:0]  presc;
  logic [DIV_W-1:0]  period;
  logic [DW-1:0]     fifo_rd_data;
  logic              fifo_empty;
  logic              fifo_rd;
  logic [DW-1:0]     dac_data;
  logic              dac_en;
  logic              sample_tick;
  logic              underrun;
  logic              ucnt_clr;
  logic [UCNT_W-1:0] ucnt;

  modport master (
    output en, presc, period, fifo_rd_data, fifo_empty, ucnt_clr,
    input  fifo_rd, dac_data, dac_en, sample_tick, underrun, ucnt
  );

  modport slave (
    input  en, presc, period, fifo_rd_data, fifo_empty, ucnt_clr,
    output fifo_rd, dac_data, dac_en, sample_tick, underrun, ucnt
  );
endinterface

// File: rtl/dac_sample_sequencer.sv
// Paces FIFO pops into the DAC register every (presc+1)*(period+1) cycles; first sample 2 edges after en, pop is combinational.
// Build macro DAC_SEQ_UNDERRUN_MUTE_EN: an underrun tick zeroes the DAC code instead of holding it.
module dac_sample_sequencer #(
  parameter int DW     = 10,
  parameter int PRE_W  = 8,
  parameter int DIV_W  = 20,
  parameter int UCNT_W = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  dac_sample_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PRE_W-1:0]  r_pre_cnt;
  logic [PRE_W-1:0]  w_pre_cnt_nxt;
  logic [DIV_W-1:0]  r_per_cnt;
  logic [DIV_W-1:0]  w_per_cnt_nxt;
  logic [DW-1:0]     r_dac_data;
  logic [DW-1:0]     w_dac_data_nxt;
  logic              r_dac_en;
  logic [UCNT_W-1:0] r_ucnt;
  logic [UCNT_W-1:0] w_ucnt_nxt;

  logic w_in_run;
  logic w_tick_pre;
  logic w_tick;
  logic w_prime_pop;
  logic w_pop;
  logic w_underrun;

  // Everything is gated by en so that the cycle that drops en never pops or ticks.
  assign w_in_run    = bus.en && (r_state == S_RUN);
  assign w_tick_pre  = w_in_run && (r_pre_cnt >= bus.presc);
  assign w_tick      = w_tick_pre && (r_per_cnt >= bus.period);
  assign w_prime_pop = bus.en && (r_state == S_PRIME) && !bus.fifo_empty;
  assign w_pop       = w_prime_pop || (w_tick && !bus.fifo_empty);
  assign w_underrun  = w_tick && bus.fifo_empty;

  always_comb begin
    w_state_nxt    = r_state;
    w_pre_cnt_nxt  = '0;
    w_per_cnt_nxt  = '0;
    w_dac_data_nxt = r_dac_data;
    if (!bus.en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_PRIME;
        end
        S_PRIME: begin
          if (w_prime_pop) begin
            w_state_nxt    = S_RUN;
            w_dac_data_nxt = bus.fifo_rd_data;
          end
        end
        S_RUN: begin
          w_pre_cnt_nxt = w_tick_pre ? '0 : r_pre_cnt + 1'b1;
          if (w_tick_pre) begin
            w_per_cnt_nxt = w_tick ? '0 : r_per_cnt + 1'b1;
          end else begin
            w_per_cnt_nxt = r_per_cnt;
          end
          if (w_tick && !bus.fifo_empty) begin
            w_dac_data_nxt = bus.fifo_rd_data;
          end
`ifdef DAC_SEQ_UNDERRUN_MUTE_EN
          else if (w_underrun) begin
            w_dac_data_nxt = '0;
          end
`else
          else begin
            w_dac_data_nxt = r_dac_data;
          end
`endif
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Clear has priority over a coincident underrun increment.
  always_comb begin
    w_ucnt_nxt = r_ucnt;
    if (bus.ucnt_clr) begin
      w_ucnt_nxt = '0;
    end else if (w_underrun && (r_ucnt != {UCNT_W{1'b1}})) begin
      w_ucnt_nxt = r_ucnt + 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      r_state    <= S_IDLE;
      r_pre_cnt  <= '0;
      r_per_cnt  <= '0;
      r_dac_data <= '0;
      r_dac_en   <= 1'b0;
      r_ucnt     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pre_cnt  <= w_pre_cnt_nxt;
      r_per_cnt  <= w_per_cnt_nxt;
      r_dac_data <= w_dac_data_nxt;
      r_dac_en   <= (w_state_nxt == S_RUN);
      r_ucnt     <= w_ucnt_nxt;
    end
  end

  assign bus.fifo_rd     = w_pop;
  assign bus.dac_data    = r_dac_data;
  assign bus.dac_en      = r_dac_en;
  assign bus.sample_tick = w_tick;
  assign bus.underrun    = w_underrun;
  assign bus.ucnt        = r_ucnt;

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Scoreboard bench for dac_sample_sequencer: sessions predict pop/underrun events by cycle number.
// A FIFO model feeds the DUT; a negedge monitor pops predictions whenever the DUT strobes.
module tb_dac_sample_sequencer;
  localparam int DW     = 10;
  localparam int PRE_W  = 8;
  localparam int DIV_W  = 20;
  localparam int UCNT_W = 8;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b1;
  always #5 HCLK = ~HCLK;

  dac_sample_sequencer_if #(.DW(DW), .PRE_W(PRE_W), .DIV_W(DIV_W), .UCNT_W(UCNT_W)) bus ();

  dac_sample_sequencer #(.DW(DW), .PRE_W(PRE_W), .DIV_W(DIV_W), .UCNT_W(UCNT_W)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  typedef struct {
    int         cyc;
    bit         rd;
    bit         un;
    bit         tk;
    bit         den;
    logic [9:0] dac;
    logic [7:0] uc;
  } ev_t;

  ev_t        exp_q[$];
  logic [9:0] fifo_q[$];
  logic [9:0] sess_data[$];
  logic [9:0] exp_dac;
  logic [7:0] exp_ucnt;
  bit         mon_on = 1'b0;
  int         n_cmp  = 0;
  int         n_err  = 0;
  int         cyc    = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, act, expv);
    end
  endtask

  // Predicted event at cycle c; advances the abstract DAC/ucnt state.
  task automatic exp_event(input int c, input bit is_pop, input bit tk, input logic [9:0] v);
    ev_t e;
    e.cyc = c; e.rd = is_pop; e.un = !is_pop; e.tk = tk; e.den = tk;
    e.dac = exp_dac; e.uc = exp_ucnt;
    exp_q.push_back(e);
    if (is_pop) begin
      exp_dac = v;
    end else begin
      if (exp_ucnt != 8'hFF) exp_ucnt = exp_ucnt + 8'd1;
`ifdef DAC_SEQ_UNDERRUN_MUTE_EN
      exp_dac = '0;
`endif
    end
  endtask

  // FIFO model: pop on a strobe seen before the edge, present the head after it.
  always begin : fifo_model
    bit pop_now;
    @(negedge HCLK);
    pop_now = bus.fifo_rd;
    @(posedge HCLK);
    if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
    #2;
    bus.fifo_empty   = (fifo_q.size() == 0);
    bus.fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 10'h2AA;
  end

  always @(negedge HCLK) begin
    if (mon_on && !HRESETn && (bus.fifo_rd || bus.underrun || bus.sample_tick)) begin
      chk("event_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        ev_t e;
        e = exp_q.pop_front();
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_flags", {bus.fifo_rd, bus.underrun, bus.sample_tick, bus.dac_en}, {e.rd, e.un, e.tk, e.den});
        chk("ev_dac_before", bus.dac_data, e.dac);
        chk("ev_ucnt_before", bus.ucnt, e.uc);
      end
    end
  end

  task automatic end_session();
    repeat (3) @(posedge HCLK);
    #1;
    chk("sess_drained", exp_q.size(), 0);
    chk("sess_dac_hold", bus.dac_data, exp_dac);
    chk("sess_ucnt", bus.ucnt, exp_ucnt);
    chk("sess_dac_en_off", bus.dac_en, 0);
    exp_q.delete();
  endtask

  // en held for L cycles with fixed presc/period and sess_data preloaded (>=1 word).
  task automatic run_session(input int p, input int q, input int L);
    int n, P, I, idx;
    @(posedge HCLK); #1;
    fifo_q = sess_data;
    bus.presc = PRE_W'(p); bus.period = DIV_W'(q);
    n = cyc; bus.en = 1'b1;
    P = n + 1; I = (p + 1) * (q + 1);
    exp_event(P, 1'b1, 1'b0, sess_data[0]);
    idx = 1;
    for (int c = P + I; c <= n + L - 1; c += I) begin
      if (idx < sess_data.size()) begin
        exp_event(c, 1'b1, 1'b1, sess_data[idx]);
        idx++;
      end else begin
        exp_event(c, 1'b0, 1'b1, 10'h0);
      end
    end
    repeat (L) @(posedge HCLK);
    #1; bus.en = 1'b0;
    end_session();
  endtask

  initial begin
    int hits, n, P, N;
    bus.en = 1'b0; bus.presc = '0; bus.period = '0; bus.ucnt_clr = 1'b0;
    bus.fifo_empty = 1'b1; bus.fifo_rd_data = '0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_dac_data", bus.dac_data, 0);
    chk("rst_dac_en", bus.dac_en, 0);
    chk("rst_ucnt", bus.ucnt, 0);
    chk("rst_comb", {bus.fifo_rd, bus.sample_tick, bus.underrun}, 0);
    @(negedge HCLK); HRESETn = 1'b0;
    exp_dac = '0; exp_ucnt = '0;
    mon_on = 1'b1;

    // Ten words 1..10, presc=1, period=15: 32-cycle spacing then two underruns.
    sess_data.delete();
    for (int i = 1; i <= 10; i++) sess_data.push_back(10'(i));
    run_session(1, 15, 360);
    chk("plan_ucnt_two", bus.ucnt, 2);

    for (int s = 0; s < 10; s++) begin
      int p, q;
      N = $urandom_range(1, 5);
      p = $urandom_range(0, 3);
      q = $urandom_range(0, 3);
      sess_data.delete();
      for (int i = 0; i < N; i++) sess_data.push_back(10'($urandom_range(0, 1023)));
      run_session(p, q, $urandom_range(2, (p + 1) * (q + 1) * (N + 2) + 4));
    end

    // PRIME with an empty FIFO: no pops, no underruns, until a word arrives.
    mon_on = 1'b0;
    @(posedge HCLK); #1;
    fifo_q.delete(); bus.presc = 8'd3; bus.period = 20'd2; bus.en = 1'b1;
    hits = 0;
    repeat (50) begin
      @(negedge HCLK);
      if (bus.fifo_rd || bus.underrun || bus.sample_tick) hits++;
    end
    chk("prime_empty_quiet", hits, 0);
    chk("prime_ucnt", bus.ucnt, exp_ucnt);
    @(posedge HCLK); #1;
    fifo_q.push_back(10'h3FF);
    @(negedge HCLK);
    chk("prime_rd", bus.fifo_rd, 1);
    chk("prime_dac_en_low", bus.dac_en, 0);
    @(posedge HCLK); #1;
    chk("prime_dac", bus.dac_data, 10'h3FF);
    chk("prime_dac_en", bus.dac_en, 1);
    bus.en = 1'b0; exp_dac = 10'h3FF;
    repeat (3) @(posedge HCLK);

    // Lower period from 100 to 10 while per_cnt is 40 (presc=2).
    mon_on = 1'b1;
    sess_data.delete();
    for (int i = 0; i < 4; i++) sess_data.push_back(10'($urandom_range(0, 1023)));
    @(posedge HCLK); #1;
    fifo_q = sess_data; bus.presc = 8'd2; bus.period = 20'd100;
    n = cyc; bus.en = 1'b1; P = n + 1;
    exp_event(P, 1'b1, 1'b0, sess_data[0]);
    exp_event(P + 41 * 3, 1'b1, 1'b1, sess_data[1]);
    exp_event(P + 41 * 3 + 11 * 3, 1'b1, 1'b1, sess_data[2]);
    exp_event(P + 41 * 3 + 22 * 3, 1'b1, 1'b1, sess_data[3]);
    repeat (122) @(posedge HCLK);
    #1; bus.period = 20'd10;
    repeat (79) @(posedge HCLK);
    #1; bus.en = 1'b0;
    end_session();

    // Drive ucnt into saturation with back-to-back underruns.
    sess_data.delete();
    sess_data.push_back(10'($urandom_range(0, 1023)));
    run_session(0, 0, 262);
    chk("ucnt_saturated", bus.ucnt, 8'hFF);

    // Clear coincident with an underrun increment.
    mon_on = 1'b0;
    @(posedge HCLK); #1;
    fifo_q.push_back(10'h055); bus.presc = '0; bus.period = '0; bus.en = 1'b1;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    bus.ucnt_clr = 1'b1;
    @(negedge HCLK);
    chk("clr_underrun_pulse", bus.underrun, 1);
    chk("clr_ucnt_before", bus.ucnt, 8'hFF);
    @(posedge HCLK); #1;
    chk("clr_ucnt_after", bus.ucnt, 0);
    bus.ucnt_clr = 1'b0; bus.en = 1'b0; exp_ucnt = '0;
    repeat (2) @(posedge HCLK);

    // Asynchronous reset in the middle of a RUN interval.
    @(posedge HCLK); #1;
    fifo_q.push_back(10'h1C3); bus.presc = 8'd1; bus.period = 20'd3; bus.en = 1'b1;
    repeat (12) @(posedge HCLK);
    #3; HRESETn = 1'b1;
    #1;
    chk("arst_dac_data", bus.dac_data, 0);
    chk("arst_dac_en", bus.dac_en, 0);
    chk("arst_ucnt", bus.ucnt, 0);
    chk("arst_comb", {bus.fifo_rd, bus.sample_tick, bus.underrun}, 0);
    bus.en = 1'b0;
    @(posedge HCLK); #1;
    fifo_q.delete(); fifo_q.push_back(10'h123);
    @(negedge HCLK); HRESETn = 1'b0;
    hits = 0;
    repeat (4) begin
      @(negedge HCLK);
      if (bus.fifo_rd || bus.dac_en) hits++;
    end
    chk("post_rst_idle", hits, 0);
    @(posedge HCLK); #1; bus.en = 1'b1;
    @(negedge HCLK);
    chk("post_rst_no_pop_idle", bus.fifo_rd, 0);
    @(negedge HCLK);
    chk("post_rst_prime_pop", bus.fifo_rd, 1);
    @(posedge HCLK); #1;
    chk("post_rst_dac", bus.dac_data, 10'h123);
    bus.en = 1'b0;
    repeat (2) @(posedge HCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
